// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweeper and response checker
//
// Drives all 2^N_IN input vectors onto a combinational unit under test in
// ascending order, holding each for HOLD cycles, samples the response at the
// end of each hold window and compares it against the EXP table.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active high
//   start          level-sampled sweep request (ignored while busy)
//   resp           unit-under-test outputs, N_OUT bits
//   stim           unit-under-test inputs, N_IN bits (MSB = input A)
//   busy           sweep in progress
//   done           sweep finished, results valid
//   pass           done with zero mismatches
//   err_count      number of mismatching vectors
//   first_fail     stim value of the first mismatch
//   first_fail_vld first_fail is valid
module tt_sweep_checker #(
    parameter int                         N_IN         = 3,
    parameter int                         N_OUT        = 2,
    parameter int                         HOLD         = 100,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXP          = 16'hD668,
    parameter bit                         STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_vld
);

    localparam int NVEC = 2 ** N_IN;
    localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0]   CNT_LAST  = CW'(HOLD - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    // Viewing the flat table as one entry per vector lets stim index it directly.
    localparam logic [NVEC-1:0][N_OUT-1:0] EXP_TAB = EXP;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [N_IN-1:0] stim_nxt;
    logic [N_IN:0]   err_nxt;
    logic [N_IN-1:0] ff_nxt;
    logic            ffv_nxt;
    logic            pass_nxt;
    logic            sample;
    logic            mismatch;

    // The counter never exceeds HOLD-1, so equality marks the sample edge.
    assign sample   = (cnt == CNT_LAST);
    assign mismatch = (resp != EXP_TAB[stim]);

    assign busy = (state == S_APPLY);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            stim           <= '0;
            cnt            <= '0;
            err_count      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            stim           <= stim_nxt;
            cnt            <= cnt_nxt;
            err_count      <= err_nxt;
            first_fail     <= ff_nxt;
            first_fail_vld <= ffv_nxt;
            pass           <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stim_nxt  = stim;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        ff_nxt    = first_fail;
        ffv_nxt   = first_fail_vld;
        pass_nxt  = pass;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_APPLY;
                    stim_nxt  = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    ff_nxt    = '0;
                    ffv_nxt   = 1'b0;
                    pass_nxt  = 1'b0;
                end
            end
            S_APPLY: begin
                if (!sample) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    if (mismatch) begin
                        err_nxt = err_count + 1'b1;
                        if (!first_fail_vld) begin
                            ff_nxt  = stim;
                            ffv_nxt = 1'b1;
                        end
                    end
                    if (stim == STIM_LAST || (STOP_ON_FAIL && mismatch)) begin
                        // stim is left on the last applied vector in DONE.
                        state_nxt = S_DONE;
                        pass_nxt  = (err_nxt == '0);
                    end else begin
                        stim_nxt = stim + 1'b1;
                        cnt_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - scoreboard bench for tt_sweep_checker
module tb_tt_sweep_checker;

    typedef struct {
        int stim;
        int err;
        int ff;
        int ffv;
        int pass;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] fault;

    logic [2:0] stim_s [3];
    logic [1:0] resp_s [3];
    logic       busy_s [3];
    logic       done_s [3];
    logic       pass_s [3];
    logic [3:0] ec_s   [3];
    logic [2:0] ff_s   [3];
    logic       ffv_s  [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int start_cyc [3] = '{-100, -100, -100};
    int hold_of   [3] = '{4, 4, 1};
    logic done_prev [3] = '{1'b0, 1'b0, 1'b0};

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // Behavioural unit under test: resp = {A^B^C, maj(A,B,C)}, fault forces maj to 0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign resp_s[g] = {^stim_s[g],
                            fault[g] ? 1'b0 :
                            ((stim_s[g][2] & stim_s[g][1]) | (stim_s[g][2] & stim_s[g][0]) |
                             (stim_s[g][1] & stim_s[g][0]))};
    end

    tt_sweep_checker #(.N_IN(3), .N_OUT(2), .HOLD(4), .EXP(16'hD668), .STOP_ON_FAIL(1'b0)) u_h4 (
        .clk(clk), .rst(rst), .start(start[0]), .resp(resp_s[0]), .stim(stim_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(ec_s[0]),
        .first_fail(ff_s[0]), .first_fail_vld(ffv_s[0]));

    tt_sweep_checker #(.N_IN(3), .N_OUT(2), .HOLD(4), .EXP(16'hD668), .STOP_ON_FAIL(1'b1)) u_stop (
        .clk(clk), .rst(rst), .start(start[1]), .resp(resp_s[1]), .stim(stim_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(ec_s[1]),
        .first_fail(ff_s[1]), .first_fail_vld(ffv_s[1]));

    tt_sweep_checker #(.N_IN(3), .N_OUT(2), .HOLD(1), .EXP(16'hD668), .STOP_ON_FAIL(1'b0)) u_h1 (
        .clk(clk), .rst(rst), .start(start[2]), .resp(resp_s[2]), .stim(stim_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(ec_s[2]),
        .first_fail(ff_s[2]), .first_fail_vld(ffv_s[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_push(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic q_pop(input int k, output exp_t e);
        case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic q_flush(input int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Record the edge at which each sweep really starts (start seen while not busy).
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++)
            if (!rst && start[k] && !busy_s[k]) start_cyc[k] = cyc;
    end

    // Monitor: stim progression, clear-on-start, and scoreboard pop on done.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (busy_s[k])
                chk($sformatf("stim_step[%0d]", k), int'(stim_s[k]), (cyc - start_cyc[k]) / hold_of[k]);
            if (!rst && cyc == start_cyc[k]) begin
                chk($sformatf("start_busy[%0d]", k), int'(busy_s[k]), 1);
                chk($sformatf("start_clear[%0d]", k),
                    int'({done_s[k], pass_s[k], ffv_s[k], ec_s[k], ff_s[k]}), 0);
            end
            if (done_s[k] && !done_prev[k]) begin
                if (q_size(k) == 0) begin
                    chk($sformatf("unexpected_done[%0d]", k), 1, 0);
                end else begin
                    exp_t e;
                    q_pop(k, e);
                    chk($sformatf("latency[%0d]", k), cyc - start_cyc[k], e.lat);
                    chk($sformatf("final_stim[%0d]", k), int'(stim_s[k]), e.stim);
                    chk($sformatf("err_count[%0d]", k), int'(ec_s[k]), e.err);
                    chk($sformatf("first_fail[%0d]", k), int'(ff_s[k]), e.ff);
                    chk($sformatf("first_fail_vld[%0d]", k), int'(ffv_s[k]), e.ffv);
                    chk($sformatf("pass[%0d]", k), int'(pass_s[k]), e.pass);
                    chk($sformatf("busy_in_done[%0d]", k), int'(busy_s[k]), 0);
                end
            end
            done_prev[k] = done_s[k];
        end
    end

    task automatic chk_reset(input int k);
        chk($sformatf("rst_stim[%0d]", k), int'(stim_s[k]), 0);
        chk($sformatf("rst_busy[%0d]", k), int'(busy_s[k]), 0);
        chk($sformatf("rst_done[%0d]", k), int'(done_s[k]), 0);
        chk($sformatf("rst_pass[%0d]", k), int'(pass_s[k]), 0);
        chk($sformatf("rst_err[%0d]", k), int'(ec_s[k]), 0);
        chk($sformatf("rst_ff[%0d]", k), int'(ff_s[k]), 0);
        chk($sformatf("rst_ffv[%0d]", k), int'(ffv_s[k]), 0);
    endtask

    task automatic pulse(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 300; i++) begin
            if (q_size(k) == 0) break;
            @(negedge clk);
        end
        if (q_size(k) != 0) begin
            chk($sformatf("timeout[%0d]", k), q_size(k), 0);
            q_flush(k);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        fault = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset(k);
        rst = 1'b0;

        // Correct unit, HOLD=4, with an ignored start pulse mid-sweep.
        q_push(0, '{7, 0, 0, 0, 1, 32});
        pulse(0);
        repeat (8) @(negedge clk);
        pulse(0);
        wait_done(0);

        // y stuck at 0, restarted directly from DONE.
        fault[0] = 1'b1;
        q_push(0, '{7, 4, 3, 1, 0, 32});
        pulse(0);
        wait_done(0);

        // STOP_ON_FAIL: stops at the first mismatch, then a clean full sweep.
        fault[1] = 1'b1;
        q_push(1, '{3, 1, 3, 1, 0, 16});
        pulse(1);
        wait_done(1);
        fault[1] = 1'b0;
        q_push(1, '{7, 0, 0, 0, 1, 32});
        pulse(1);
        wait_done(1);

        // HOLD=1: correct then faulty unit.
        q_push(2, '{7, 0, 0, 0, 1, 8});
        pulse(2);
        wait_done(2);
        fault[2] = 1'b1;
        q_push(2, '{7, 4, 3, 1, 0, 8});
        pulse(2);
        wait_done(2);

        // Asynchronous reset while stim==5 on a faulty sweep, then a clean sweep.
        fault[0] = 1'b1;
        pulse(0);
        begin
            int i;
            for (i = 0; i < 100; i++) begin
                if (stim_s[0] == 3'd5) break;
                @(negedge clk);
            end
            chk("reach_stim5", int'(stim_s[0]), 5);
        end
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk_reset(k);
        @(negedge clk);
        rst      = 1'b0;
        fault[0] = 1'b0;
        q_push(0, '{7, 0, 0, 0, 1, 32});
        pulse(0);
        wait_done(0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Parametrised, self-checking truth-table sweeper for combinational lab designs.
- Drives every one of the 2^N_IN input combinations onto a DUT in ascending order, holding each for HOLD clock cycles.
- Samples the DUT response at the end of each hold window, compares it against an expected-response table given as a parameter, and reports error count, first failing vector and pass/fail.
- Sits in the lab bench between a start control and the unit under test; replaces hand-written per-vector delay stimulus.

Parameters:
- N_IN, 3: number of DUT inputs; sweep length is 2^N_IN vectors (1..8).
- N_OUT, 2: number of DUT outputs compared (1..8).
- HOLD, 100: cycles each vector is held; must be >= 1.
- EXP, 16'hD668: expected table, N_OUT*2^N_IN bits; EXP[i*N_OUT +: N_OUT] is the expected resp for stim == i.
- STOP_ON_FAIL, 0: 0 = sweep all vectors; 1 = terminate at the first mismatch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level-sampled request to begin a sweep.
- resp  in  N_OUT  DUT outputs.
- stim  out  N_IN  DUT inputs; MSB = first input (A), LSB = last input (C).
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; results valid.
- pass  out  1  done and zero mismatches.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_fail  out  N_IN  stim value of the first mismatch.
- first_fail_vld  out  1  first_fail holds a valid value.

Behaviour:
- Reset (async, rst=1): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_vld=0, hold counter=0. Reset mid-sweep aborts immediately; no partial results are retained.
- FSM states:
  - IDLE.
  - APPLY: busy=1.
  - DONE: done=1.
- IDLE/DONE, start=1 at an edge:
  - Go to APPLY.
  - stim=0, counter=0.
  - Clear err_count, first_fail, first_fail_vld, done, pass.
- APPLY, each edge:
  - If counter < HOLD-1: counter++.
  - Else (sample edge):
    - Compare resp with EXP[stim*N_OUT +: N_OUT].
    - On mismatch: err_count++. If first_fail_vld=0, set first_fail=stim and first_fail_vld=1.
    - Then:
      - If stim == 2^N_IN-1, or (STOP_ON_FAIL=1 and mismatch): go to DONE.
      - Otherwise stim++ and counter=0.
- Timing:
  - resp is sampled at the edge HOLD cycles after the edge where that vector was applied.
  - done rises at the final sample edge, HOLD*2^N_IN edges after the start edge (full sweep).
- DONE:
  - Holds all results and the final stim value until start or rst.
  - pass = (err_count==0), registered together with done.
- start is ignored while busy=1. Holding start high continuously restarts a sweep on the edge after each done.
- err_count cannot overflow (max 2^N_IN); no saturation logic required.
- HOLD=1: a new vector every cycle; the sample edge is every edge in APPLY.
- stim is a registered output and is glitch-free.

Test Plan (N_IN=3, N_OUT=2, EXP=16'hD668; behavioural DUT resp={x,y} with x=A^B^C, y=majority(A,B,C); HOLD=4 unless stated):
- Correct DUT, start pulse at t0 -> stim steps 0..7 every 4 cycles; done=1 and pass=1 32 edges after start; err_count=0; first_fail_vld=0.
- DUT with y stuck at 0 -> mismatches at stim 3,5,6,7; done after 32 edges; err_count=4, first_fail=3, first_fail_vld=1, pass=0.
- Same faulty DUT, STOP_ON_FAIL=1 -> done 16 edges after start with stim=3, err_count=1, first_fail=3, pass=0.
- Assert rst while stim=5 mid-sweep -> all outputs return to reset values immediately (asynchronously); a new start gives a full clean 32-cycle sweep.
- Pulse start again while busy -> no effect on the sweep. Start in DONE -> results cleared on that edge and a new sweep runs from stim=0.
- HOLD=1 with correct DUT -> stim changes every cycle; done and pass asserted 8 edges after start.
